// File: rtl/oflow_conflict_resolve_pkg.sv
// Shared types and default widths for the score-board conflict-resolve block.
package oflow_conflict_resolve_pkg;

  localparam int CR_ROWS    = 8;
  localparam int CR_ROW_W   = 3;
  localparam int CR_ID_W    = 8;
  localparam int CR_SCORE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CMP,
    WRITE,
    DONE
  } cr_state_e;

endpackage

// File: rtl/oflow_cr_loser_sel.sv
// Decides whether two rows hold the same active ID and which one gives way.
// The worse (higher) score loses; on a tie the later row j loses.
module oflow_cr_loser_sel #(
  parameter int ROW_W   = 3,
  parameter int ID_W    = 8,
  parameter int SCORE_W = 8
) (
  input  logic [ID_W-1:0]    id_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic [ROW_W-1:0]   row_i,
  input  logic [ID_W-1:0]    id_j,
  input  logic [SCORE_W-1:0] score_j,
  input  logic [ROW_W-1:0]   row_j,
  output logic               conflict,
  output logic [ROW_W-1:0]   loser_row
);

  always_comb begin
    conflict  = (id_i == id_j);
    loser_row = (score_j >= score_i) ? row_j : row_i;
  end

endmodule

// File: rtl/oflow_conflict_resolve.sv
// Scans valid score-board rows pairwise for duplicate active IDs and repairs each
// conflict by flipping the loser to its second choice, or giving it a fresh ID.
module oflow_conflict_resolve
  import oflow_conflict_resolve_pkg::*;
#(
  parameter int ROWS    = CR_ROWS,
  parameter int ROW_W   = CR_ROW_W,
  parameter int ID_W    = CR_ID_W,
  parameter int SCORE_W = CR_SCORE_W
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               ready_new_frame,
  input  logic               start_cr,
  input  logic [ROW_W:0]     num_rows,
  input  logic [ID_W-1:0]    next_free_id_in,
  input  logic [SCORE_W-1:0] score_to_cr,
  input  logic [ID_W-1:0]    id_to_cr,
  output logic [ROW_W-1:0]   row_sel_from_cr,
  output logic [ROW_W-1:0]   row_to_change,
  output logic               write_to_pointer,
  output logic               data_from_cr_pointer,
  output logic               write_to_id,
  output logic [ID_W-1:0]    data_from_cr_id,
  output logic [ID_W-1:0]    next_free_id_out,
  output logic               id_overflow,
  output logic               busy_cr,
  output logic               done_cr
);

  localparam logic [ROW_W:0] ROWS_N = (ROW_W+1)'(ROWS);
  localparam logic [ROW_W:0] ONE_N  = (ROW_W+1)'(1);
  localparam logic [ROW_W:0] TWO_N  = (ROW_W+1)'(2);

  cr_state_e          state, state_next;
  logic [ROW_W:0]     n_rows;
  logic [ROW_W-1:0]   i_row, j_row, loser;
  logic [ID_W-1:0]    id_i;
  logic [SCORE_W-1:0] score_i;
  logic [ROWS-1:0]    shadow;
  logic [ID_W-1:0]    next_free;
  logic               overflow;

  logic               conflict;
  logic [ROW_W-1:0]   sel_loser;
  logic [ROW_W:0]     rows_clamped;
  logic               last_j, last_i;

  oflow_cr_loser_sel #(
    .ROW_W   (ROW_W),
    .ID_W    (ID_W),
    .SCORE_W (SCORE_W)
  ) u_loser_sel (
    .id_i      (id_i),
    .score_i   (score_i),
    .row_i     (i_row),
    .id_j      (id_to_cr),
    .score_j   (score_to_cr),
    .row_j     (j_row),
    .conflict  (conflict),
    .loser_row (sel_loser)
  );

  always_comb begin
    rows_clamped = (num_rows > ROWS_N) ? ROWS_N : num_rows;
    last_j       = ({1'b0, j_row} == (n_rows - ONE_N));
    last_i       = ({1'b0, i_row} == (n_rows - TWO_N));
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)             state <= IDLE;
    else if (ready_new_frame) state <= IDLE;
    else                      state <= state_next;
  end

  always_comb begin
    state_next           = state;
    row_sel_from_cr      = '0;
    row_to_change        = '0;
    write_to_pointer     = 1'b0;
    data_from_cr_pointer = 1'b0;
    write_to_id          = 1'b0;
    data_from_cr_id      = '0;
    busy_cr              = (state != IDLE);
    done_cr              = (state == DONE);
    case (state)
      IDLE:  if (start_cr) state_next = (rows_clamped >= TWO_N) ? LOAD : DONE;
      LOAD: begin
        row_sel_from_cr = i_row;
        state_next      = CMP;
      end
      CMP: begin
        row_sel_from_cr = j_row;
        if (conflict)    state_next = WRITE;
        else if (last_j) state_next = last_i ? DONE : LOAD;
      end
      // An already-flipped loser falls back to slot 0 carrying a fresh ID.
      WRITE: begin
        row_to_change        = loser;
        write_to_pointer     = 1'b1;
        data_from_cr_pointer = ~shadow[loser];
        write_to_id          = shadow[loser];
        data_from_cr_id      = shadow[loser] ? next_free : '0;
        state_next           = LOAD;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      n_rows <= '0; i_row <= '0; j_row <= '0; loser <= '0;
      id_i <= '0; score_i <= '0; shadow <= '0; next_free <= '0; overflow <= 1'b0;
    end else if (ready_new_frame) begin
      n_rows <= '0; i_row <= '0; j_row <= '0; loser <= '0;
      id_i <= '0; score_i <= '0; shadow <= '0; next_free <= '0; overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_cr) begin
          n_rows    <= rows_clamped;
          next_free <= next_free_id_in;
          i_row     <= '0;
        end
        LOAD: begin
          id_i    <= id_to_cr;
          score_i <= score_to_cr;
          j_row   <= i_row + ROW_W'(1);
        end
        CMP: begin
          if (conflict)    loser <= sel_loser;
          else if (last_j) i_row <= i_row + ROW_W'(1);
          else             j_row <= j_row + ROW_W'(1);
        end
        // Any repair can create a new duplicate with earlier rows, so rescan from row 0.
        WRITE: begin
          i_row <= '0;
          if (shadow[loser]) begin
            next_free <= next_free + ID_W'(1);
            if (next_free == '1) overflow <= 1'b1;
          end else begin
            shadow[loser] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign next_free_id_out = next_free;
  assign id_overflow      = overflow;

endmodule

// File: tb/tb_oflow_conflict_resolve.sv
// Self-checking bench: score-board model, table-driven vectors, directed corner
// sequences and randomized frames checked against an algorithmic reference model.
module tb_oflow_conflict_resolve;
  import oflow_conflict_resolve_pkg::*;

  localparam int LIMIT = 3000;

  logic       clk = 1'b0;
  logic       reset_N = 1'b0;
  logic       ready_new_frame = 1'b0;
  logic       start_cr = 1'b0;
  logic [3:0] num_rows = '0;
  logic [7:0] next_free_id_in = '0;
  logic [7:0] score_to_cr, id_to_cr;
  logic [2:0] row_sel_from_cr, row_to_change;
  logic       write_to_pointer, data_from_cr_pointer, write_to_id;
  logic [7:0] data_from_cr_id, next_free_id_out;
  logic       id_overflow, busy_cr, done_cr;

  oflow_conflict_resolve dut (
    .clk                  (clk),
    .reset_N              (reset_N),
    .ready_new_frame      (ready_new_frame),
    .start_cr             (start_cr),
    .num_rows             (num_rows),
    .next_free_id_in      (next_free_id_in),
    .score_to_cr          (score_to_cr),
    .id_to_cr             (id_to_cr),
    .row_sel_from_cr      (row_sel_from_cr),
    .row_to_change        (row_to_change),
    .write_to_pointer     (write_to_pointer),
    .data_from_cr_pointer (data_from_cr_pointer),
    .write_to_id          (write_to_id),
    .data_from_cr_id      (data_from_cr_id),
    .next_free_id_out     (next_free_id_out),
    .id_overflow          (id_overflow),
    .busy_cr              (busy_cr),
    .done_cr              (done_cr)
  );

  always #5 clk = ~clk;

  // Score board: combinational read of the active pair, posedge writes.
  int         ld_id0[8], ld_s0[8], ld_id1[8], ld_s1[8];
  logic       load_req = 1'b0;
  logic [7:0] id0_b[8], s0_b[8], id1_b[8], s1_b[8];
  logic       ptr_b[8];

  always_comb begin
    id_to_cr    = ptr_b[row_sel_from_cr] ? id1_b[row_sel_from_cr] : id0_b[row_sel_from_cr];
    score_to_cr = ptr_b[row_sel_from_cr] ? s1_b[row_sel_from_cr] : s0_b[row_sel_from_cr];
  end

  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < 8; r++) begin
        id0_b[r] <= 8'(ld_id0[r]); s0_b[r] <= 8'(ld_s0[r]);
        id1_b[r] <= 8'(ld_id1[r]); s1_b[r] <= 8'(ld_s1[r]);
        ptr_b[r] <= 1'b0;
      end
    end else begin
      if (write_to_pointer) ptr_b[row_to_change] <= data_from_cr_pointer;
      if (write_to_id) id0_b[row_to_change] <= data_from_cr_id;
    end
  end

  int checks = 0;
  int passes = 0;
  int lat, pw, iw;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  function automatic longint board_act_pack();
    longint v = 0;
    for (int r = 0; r < 8; r++) v |= longint'(ptr_b[r] ? id1_b[r] : id0_b[r]) << (8 * r);
    return v;
  endfunction

  task automatic load_board();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic new_frame();
    @(negedge clk); ready_new_frame = 1'b1;
    @(negedge clk); ready_new_frame = 1'b0;
  endtask

  // Pulses start_cr and counts clocks until done_cr; optionally re-pulses start mid-scan.
  task automatic apply_stimulus(input int n, input int nfi, input int repulse);
    @(negedge clk);
    num_rows = 4'(n); next_free_id_in = 8'(nfi); start_cr = 1'b1;
    lat = 0; pw = 0; iw = 0;
    while (lat < LIMIT) begin
      @(negedge clk);
      start_cr = 1'b0;
      lat++;
      if (write_to_pointer) pw++;
      if (write_to_id) iw++;
      if (done_cr) break;
      if (lat == repulse) begin start_cr = 1'b1; num_rows = 4'd1; end
    end
    if (lat >= LIMIT) begin
      $display("[TB] FAIL scan_timeout: got no done_cr expected done within %0d", LIMIT);
      checks++;
      new_frame();
    end
  endtask

  // Reference model: repeatedly find the first duplicate pair in scan order and repair it.
  int     m_id0[8], m_id1[8], m_s0[8], m_s1[8], m_ptr[8];
  int     m_lat, m_pw, m_iw, m_nfo, m_ovf;
  longint m_act;

  function automatic int m_act_id(input int r);
    return m_ptr[r] ? m_id1[r] : m_id0[r];
  endfunction

  function automatic int m_score(input int r);
    return m_ptr[r] ? m_s1[r] : m_s0[r];
  endfunction

  task automatic model_run(input int n_in, input int nfi);
    int n, total, nf, fi, fj, cost, l;
    int sh[8];
    n = (n_in > 8) ? 8 : n_in;
    total = 0; nf = nfi; m_pw = 0; m_iw = 0; m_ovf = 0;
    for (int r = 0; r < 8; r++) begin
      m_id0[r] = ld_id0[r]; m_id1[r] = ld_id1[r];
      m_s0[r] = ld_s0[r]; m_s1[r] = ld_s1[r]; m_ptr[r] = 0; sh[r] = 0;
    end
    for (int guard = 0; guard < 100; guard++) begin
      cost = 0; fi = -1; fj = -1;
      for (int i = 0; i < n - 1 && fi < 0; i++) begin
        cost++;
        for (int j = i + 1; j < n; j++) begin
          cost++;
          if (m_act_id(i) == m_act_id(j)) begin fi = i; fj = j; break; end
        end
      end
      total += cost;
      if (fi < 0) break;
      total++;
      l = (m_score(fj) >= m_score(fi)) ? fj : fi;
      m_pw++;
      if (sh[l] == 0) begin
        sh[l] = 1; m_ptr[l] = 1;
      end else begin
        m_id0[l] = nf; m_ptr[l] = 0; m_iw++;
        nf = (nf + 1) % 256;
        if (nf == 0) m_ovf = 1;
      end
    end
    m_lat = total + 1;
    m_nfo = nf;
    m_act = 0;
    for (int r = 0; r < 8; r++) m_act |= longint'(m_act_id(r)) << (8 * r);
  endtask

  task automatic check_output(input string tag, input int e_lat, input int e_pw, input int e_iw,
                              input int e_nfo, input int e_ovf, input longint e_act);
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_ptr_writes"}, pw, e_pw);
    check({tag, "_id_writes"}, iw, e_iw);
    check({tag, "_next_free"}, next_free_id_out, e_nfo);
    check({tag, "_overflow"}, id_overflow, e_ovf);
    check({tag, "_active_ids"}, board_act_pack(), e_act);
    @(negedge clk);
    check({tag, "_idle_after"}, {busy_cr, done_cr}, 0);
  endtask

  typedef struct {
    int n; int nfi;
    int id0[8]; int s0[8]; int id1[8]; int s1[8];
    int lat; int pw; int iw; int nfo; int ovf;
    int act[8];
  } vec_t;

  vec_t tv[8];

  task automatic load_vec(input int k);
    for (int r = 0; r < 8; r++) begin
      ld_id0[r] = tv[k].id0[r]; ld_s0[r] = tv[k].s0[r];
      ld_id1[r] = tv[k].id1[r]; ld_s1[r] = tv[k].s1[r];
    end
    load_board();
  endtask

  initial begin
    longint e_act;
    string  tag;

    for (int k = 0; k < 8; k++) begin
      tv[k].id1 = '{40, 41, 42, 43, 44, 45, 46, 47};
      tv[k].s1  = '{9, 9, 9, 9, 9, 9, 9, 9};
      tv[k].s0  = '{1, 2, 3, 4, 5, 6, 7, 8};
      tv[k].nfi = 20; tv[k].pw = 0; tv[k].iw = 0; tv[k].nfo = 20; tv[k].ovf = 0;
    end
    // Conflict-free, four rows
    tv[0].n = 4; tv[0].id0 = '{5, 7, 9, 11, 0, 0, 0, 0}; tv[0].lat = 10;
    tv[0].act = '{5, 7, 9, 11, 0, 0, 0, 0};
    // Rows 0/2 share 5, row 2 scores worse and flips to 8
    tv[1].n = 4; tv[1].id0 = '{5, 7, 5, 11, 0, 0, 0, 0}; tv[1].s0 = '{10, 1, 20, 2, 0, 0, 0, 0};
    tv[1].id1[2] = 8; tv[1].s1[2] = 30; tv[1].lat = 14; tv[1].pw = 1;
    tv[1].act = '{5, 7, 8, 11, 0, 0, 0, 0};
    // Tie on rows 1/3: the later row loses
    tv[2].n = 4; tv[2].id0 = '{4, 6, 9, 6, 0, 0, 0, 0}; tv[2].s0 = '{1, 15, 2, 15, 0, 0, 0, 0};
    tv[2].id1[3] = 12; tv[2].lat = 18; tv[2].pw = 1;
    tv[2].act = '{4, 6, 9, 12, 0, 0, 0, 0};
    // Second choice collides again and a fresh ID is issued
    tv[3].n = 4; tv[3].id0 = '{8, 7, 7, 11, 0, 0, 0, 0}; tv[3].s0 = '{5, 10, 20, 2, 0, 0, 0, 0};
    tv[3].id1[2] = 8; tv[3].s1[2] = 30; tv[3].nfi = 100; tv[3].lat = 21; tv[3].pw = 2;
    tv[3].iw = 1; tv[3].nfo = 101; tv[3].act = '{8, 7, 100, 11, 0, 0, 0, 0};
    // Same, with the fresh-ID counter wrapping
    tv[4] = tv[3]; tv[4].nfi = 255; tv[4].nfo = 0; tv[4].ovf = 1;
    tv[4].act = '{8, 7, 255, 11, 0, 0, 0, 0};
    // One row: nothing to compare
    tv[5].n = 1; tv[5].id0 = '{3, 3, 3, 3, 3, 3, 3, 3}; tv[5].nfi = 7; tv[5].nfo = 7; tv[5].lat = 1;
    tv[5].act = '{3, 3, 3, 3, 3, 3, 3, 3};
    // num_rows above the board size is clamped to 8
    tv[6].n = 15; tv[6].id0 = '{1, 2, 3, 4, 5, 6, 7, 8}; tv[6].lat = 36;
    tv[6].act = '{1, 2, 3, 4, 5, 6, 7, 8};
    // Two rows where row i has the worse score and loses
    tv[7].n = 2; tv[7].id0 = '{9, 9, 0, 0, 0, 0, 0, 0}; tv[7].s0 = '{3, 1, 0, 0, 0, 0, 0, 0};
    tv[7].id1[0] = 4; tv[7].lat = 6; tv[7].pw = 1;
    tv[7].act = '{4, 9, 0, 0, 0, 0, 0, 0};

    repeat (2) @(negedge clk);
    check("reset_busy_done", {busy_cr, done_cr}, 0);
    check("reset_strobes", {write_to_pointer, write_to_id, data_from_cr_pointer}, 0);
    check("reset_rows", {row_sel_from_cr, row_to_change}, 0);
    check("reset_ids", {next_free_id_out, data_from_cr_id, 7'd0, id_overflow}, 0);
    reset_N = 1'b1;

    for (int k = 0; k < 8; k++) begin
      load_vec(k);
      new_frame();
      apply_stimulus(tv[k].n, tv[k].nfi, 0);
      e_act = 0;
      for (int r = 0; r < 8; r++) e_act |= longint'(tv[k].act[r]) << (8 * r);
      tag = $sformatf("vec%0d", k);
      check_output(tag, tv[k].lat, tv[k].pw, tv[k].iw, tv[k].nfo, tv[k].ovf, e_act);
    end

    // A second start_cr while busy must not disturb the running scan.
    load_vec(0);
    new_frame();
    apply_stimulus(4, 20, 3);
    check_output("restart_ignored", 10, 0, 0, 20, 0, 64'h0B09_0705);

    // Leave shadow[3] set, then abort a later scan and confirm the abort cleared it.
    load_vec(2);
    new_frame();
    apply_stimulus(4, 20, 0);
    check("abort_setup_ptr_writes", pw, 1);
    ld_id0 = '{4, 6, 9, 9, 0, 0, 0, 0}; ld_s0 = '{1, 2, 3, 4, 0, 0, 0, 0};
    ld_id1 = '{40, 41, 42, 20, 0, 0, 0, 0}; ld_s1 = '{9, 9, 9, 9, 0, 0, 0, 0};
    load_board();
    @(negedge clk);
    num_rows = 4'd4; start_cr = 1'b1;
    pw = 0; iw = 0; lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start_cr = 1'b0;
      if (write_to_pointer || write_to_id) pw++;
      if (done_cr) lat++;
      if (c == 4) begin
        check("abort_busy_before", busy_cr, 1);
        ready_new_frame = 1'b1;
      end
      if (c == 5) begin
        check("abort_busy_after", busy_cr, 0);
        ready_new_frame = 1'b0;
      end
    end
    check("abort_no_done", lat, 0);
    check("abort_no_strobes", pw, 0);
    apply_stimulus(4, 20, 0);
    check_output("after_abort", 20, 1, 0, 20, 0, 64'h1409_0604);

    // Randomized frames with small ID/score ranges so duplicates and ties are common.
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < 8; r++) begin
        ld_id0[r] = $urandom_range(0, 5); ld_id1[r] = $urandom_range(0, 7);
        ld_s0[r] = $urandom_range(0, 3); ld_s1[r] = $urandom_range(0, 3);
      end
      load_board();
      new_frame();
      begin
        int n, nfi;
        n = $urandom_range(0, 10);
        nfi = $urandom_range(100, 200);
        model_run(n, nfi);
        apply_stimulus(n, nfi, 0);
      end
      tag = $sformatf("rand%0d", t);
      check_output(tag, m_lat, m_pw, m_iw, m_nfo, m_ovf, m_act);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
